// File: rtl/mcpu_pkg.sv
// Shared encodings for the MCPU controller: opcodes, functs, ALU commands, states, mux selects.
// Also holds the per-state control decode used to register the controller outputs.
package mcpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_XOR  = 3'd2,
        ALU_SLT  = 3'd3,
        ALU_AND  = 3'd4,
        ALU_NAND = 3'd5,
        ALU_NOR  = 3'd6,
        ALU_OR   = 3'd7
    } alu_op_t;

    typedef enum logic [5:0] {
        S_FETCH      = 6'd0,
        S_DECODE     = 6'd1,
        S_MEM_ADDR   = 6'd2,
        S_LW_READ    = 6'd3,
        S_LW_WB      = 6'd4,
        S_SW_WRITE   = 6'd5,
        S_R_EXEC     = 6'd6,
        S_R_WB       = 6'd7,
        S_I_EXEC     = 6'd8,
        S_I_WB       = 6'd9,
        S_BR_TARGET  = 6'd10,
        S_BR_LATCH   = 6'd11,
        S_BR_RESOLVE = 6'd12,
        S_JUMP       = 6'd13,
        S_JAL        = 6'd14,
        S_JR_EXEC    = 6'd15,
        S_JR_PC      = 6'd16
    } state_t;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_A     = 2'd1;
    localparam logic [1:0] SRCA_BEN   = 2'd2;
    localparam logic [1:0] SRCA_ZERO  = 2'd3;
    localparam logic [1:0] SRCB_BRIMM = 2'd0;
    localparam logic [1:0] SRCB_IMM   = 2'd1;
    localparam logic [1:0] SRCB_B     = 2'd2;
    localparam logic [1:0] SRCB_FOUR  = 2'd3;
    localparam logic [1:0] PCSRC_BR   = 2'd0;
    localparam logic [1:0] PCSRC_JUMP = 2'd1;
    localparam logic [1:0] PCSRC_PC4  = 2'd2;
    localparam logic [1:0] PCSRC_ALU  = 2'd3;
    localparam logic       DST_RD     = 1'b0;
    localparam logic       DST_RT     = 1'b1;
    localparam logic       REGIN_MDR  = 1'b0;
    localparam logic       REGIN_ALU  = 1'b1;
    localparam logic       MEMIN_PC   = 1'b0;
    localparam logic       MEMIN_ALU  = 1'b1;

    typedef struct packed {
        logic       pc_we;
        logic       ir_we;
        logic       mem_we;
        logic       reg_we;
        logic       a_we;
        logic       b_we;
        logic       ben_we;
        logic       save_pc4;
        logic       mem_in;
        logic       dst;
        logic       reg_in;
        logic       immer;
        logic       jal;
        logic       beq_bne;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        alu_op_t    alu_op;
        logic [1:0] pc_src;
    } ctrl_t;

    function automatic ctrl_t ctrl_decode(input state_t s, input logic [5:0] opcode,
                                          input logic [5:0] funct);
        ctrl_t c;
        c        = '0;
        c.alu_op = ALU_ADD;
        case (s)
            S_FETCH: begin
                c.ir_we     = 1'b1;
                c.save_pc4  = 1'b1;
                c.mem_in    = MEMIN_PC;
                c.alu_src_a = SRCA_PC;
                c.alu_src_b = SRCB_FOUR;
            end
            // alu_reg captures PC+4 here so JAL can later write it as the link address
            S_DECODE: begin
                c.a_we      = 1'b1;
                c.b_we      = 1'b1;
                c.pc_we     = 1'b1;
                c.pc_src    = PCSRC_PC4;
                c.alu_src_a = SRCA_PC;
                c.alu_src_b = SRCB_FOUR;
            end
            S_MEM_ADDR: begin
                c.alu_src_a = SRCA_A;
                c.alu_src_b = SRCB_IMM;
            end
            S_LW_READ:  c.mem_in = MEMIN_ALU;
            S_LW_WB: begin
                c.reg_we = 1'b1;
                c.dst    = DST_RT;
                c.reg_in = REGIN_MDR;
            end
            S_SW_WRITE: begin
                c.mem_in = MEMIN_ALU;
                c.mem_we = 1'b1;
            end
            S_R_EXEC: begin
                c.alu_src_a = SRCA_A;
                c.alu_src_b = SRCB_B;
                c.alu_op    = (funct == FN_SUB) ? ALU_SUB :
                              (funct == FN_SLT) ? ALU_SLT : ALU_ADD;
            end
            S_R_WB: begin
                c.reg_we = 1'b1;
                c.dst    = DST_RD;
                c.reg_in = REGIN_ALU;
            end
            S_I_EXEC: begin
                c.alu_src_a = SRCA_A;
                c.alu_src_b = SRCB_IMM;
                if (opcode == OP_XORI) begin
                    c.alu_op = ALU_XOR;
                    c.immer  = 1'b1;
                end
            end
            S_I_WB: begin
                c.reg_we = 1'b1;
                c.dst    = DST_RT;
                c.reg_in = REGIN_ALU;
            end
            S_BR_TARGET: begin
                c.alu_src_a = SRCA_PC;
                c.alu_src_b = SRCB_BRIMM;
            end
            S_BR_LATCH: c.ben_we = 1'b1;
            S_BR_RESOLVE: begin
                c.alu_src_a = SRCA_A;
                c.alu_src_b = SRCB_B;
                c.alu_op    = ALU_SUB;
                c.pc_we     = 1'b1;
                c.pc_src    = PCSRC_BR;
                c.beq_bne   = (opcode == OP_BNE);
            end
            S_JUMP: begin
                c.pc_we  = 1'b1;
                c.pc_src = PCSRC_JUMP;
            end
            S_JAL: begin
                c.pc_we  = 1'b1;
                c.pc_src = PCSRC_JUMP;
                c.reg_we = 1'b1;
                c.jal    = 1'b1;
                c.reg_in = REGIN_ALU;
            end
            S_JR_EXEC: begin
                c.alu_src_a = SRCA_A;
                c.alu_src_b = SRCB_B;
            end
            S_JR_PC: begin
                c.pc_we  = 1'b1;
                c.pc_src = PCSRC_ALU;
            end
            default: c.alu_op = ALU_ADD;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/instr_fields.sv
// Splits the held instruction word into its MIPS fields.
// Purely combinational, zero latency; no flow control.
module instr_fields (
    input  logic [31:0] instruction,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm,
    output logic [25:0] address
);

    assign opcode  = instruction[31:26];
    assign rs      = instruction[25:21];
    assign rt      = instruction[20:16];
    assign rd      = instruction[15:11];
    assign shamt   = instruction[10:6];
    assign funct   = instruction[5:0];
    assign imm     = instruction[15:0];
    assign address = instruction[25:0];

endmodule

// File: rtl/mcpu_control_fsm.sv
// Multi-cycle MIPS-subset controller: sequences states and drives all datapath controls.
// Outputs are registered alongside the state (Moore); no backpressure, one state per cycle.
module mcpu_control_fsm
    import mcpu_pkg::*;
#(
    parameter int STATE_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        instruction,
    output logic [4:0]         rs,
    output logic [4:0]         rt,
    output logic [4:0]         rd,
    output logic [4:0]         shamt,
    output logic [5:0]         funct,
    output logic [15:0]        imm,
    output logic [25:0]        address,
    output logic [STATE_W-1:0] state,
    output logic               pc_we,
    output logic               ir_we,
    output logic               mem_we,
    output logic               reg_we,
    output logic               a_we,
    output logic               b_we,
    output logic               ben_we,
    output logic               save_pc4,
    output logic               mem_in,
    output logic               dst,
    output logic               reg_in,
    output logic               immer,
    output logic               jal,
    output logic               beq_bne,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_op,
    output logic [1:0]         pc_src
);

    logic [5:0] opcode;
    state_t     state_q;
    state_t     nxt;
    ctrl_t      ctrl_q;

    instr_fields u_fields (
        .instruction (instruction),
        .opcode      (opcode),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .shamt       (shamt),
        .funct       (funct),
        .imm         (imm),
        .address     (address)
    );

    always_comb begin
        nxt = S_FETCH;
        case (state_q)
            S_FETCH:  nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:     nxt = S_MEM_ADDR;
                    OP_RTYPE: begin
                        if (funct == FN_ADD || funct == FN_SUB || funct == FN_SLT)
                            nxt = S_R_EXEC;
                        else if (funct == FN_JR)
                            nxt = S_JR_EXEC;
                        else
                            nxt = S_FETCH;
                    end
                    OP_ADDI, OP_XORI: nxt = S_I_EXEC;
                    OP_BEQ, OP_BNE:   nxt = S_BR_TARGET;
                    OP_J:             nxt = S_JUMP;
                    OP_JAL:           nxt = S_JAL;
                    default:          nxt = S_FETCH;
                endcase
            end
            S_MEM_ADDR:   nxt = (opcode == OP_LW) ? S_LW_READ : S_SW_WRITE;
            S_LW_READ:    nxt = S_LW_WB;
            S_R_EXEC:     nxt = S_R_WB;
            S_I_EXEC:     nxt = S_I_WB;
            S_BR_TARGET:  nxt = S_BR_LATCH;
            S_BR_LATCH:   nxt = S_BR_RESOLVE;
            S_JR_EXEC:    nxt = S_JR_PC;
            default:      nxt = S_FETCH;
        endcase
    end

    // Outputs are decoded from the next state so they line up with state_q after the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            ctrl_q  <= ctrl_decode(S_FETCH, opcode, funct);
        end else begin
            state_q <= nxt;
            ctrl_q  <= ctrl_decode(nxt, opcode, funct);
        end
    end

    assign state     = STATE_W'(state_q);
    assign pc_we     = ctrl_q.pc_we    & ~reset;
    assign ir_we     = ctrl_q.ir_we    & ~reset;
    assign mem_we    = ctrl_q.mem_we   & ~reset;
    assign reg_we    = ctrl_q.reg_we   & ~reset;
    assign a_we      = ctrl_q.a_we     & ~reset;
    assign b_we      = ctrl_q.b_we     & ~reset;
    assign ben_we    = ctrl_q.ben_we   & ~reset;
    assign save_pc4  = ctrl_q.save_pc4 & ~reset;
    assign mem_in    = ctrl_q.mem_in;
    assign dst       = ctrl_q.dst;
    assign reg_in    = ctrl_q.reg_in;
    assign immer     = ctrl_q.immer;
    assign jal       = ctrl_q.jal;
    assign beq_bne   = ctrl_q.beq_bne;
    assign alu_src_a = ctrl_q.alu_src_a;
    assign alu_src_b = ctrl_q.alu_src_b;
    assign alu_op    = ctrl_q.alu_op;
    assign pc_src    = ctrl_q.pc_src;

endmodule

// File: tb/tb_mcpu_control_fsm.sv
// Directed plus random instruction stream checked against a table-driven model of the controller.
module tb_mcpu_control_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] address;
    logic [5:0]  state;
    logic        pc_we, ir_we, mem_we, reg_we, a_we, b_we, ben_we, save_pc4;
    logic        mem_in, dst, reg_in, immer, jal, beq_bne;
    logic [1:0]  alu_src_a, alu_src_b, pc_src;
    logic [2:0]  alu_op;

    int total = 0;
    int bad   = 0;
    int path[$];

    // {pc_we, ir_we, mem_we, reg_we, a_we, b_we, ben_we, save_pc4} per state
    localparam logic [7:0] WE_T [17] = '{
        8'b01000001, 8'b10001100, 8'b00000000, 8'b00000000, 8'b00010000,
        8'b00100000, 8'b00000000, 8'b00010000, 8'b00000000, 8'b00010000,
        8'b00000000, 8'b00000010, 8'b10000000, 8'b10000000, 8'b10010000,
        8'b00000000, 8'b10000000};
    // {mem_in, dst, reg_in, jal, alu_src_a, alu_src_b, pc_src} per state
    localparam logic [9:0] MUX_T [17] = '{
        10'b0000_00_11_00, 10'b0000_00_11_10, 10'b0000_01_01_00, 10'b1000_00_00_00,
        10'b0100_00_00_00, 10'b1000_00_00_00, 10'b0000_01_10_00, 10'b0010_00_00_00,
        10'b0000_01_01_00, 10'b0110_00_00_00, 10'b0000_00_00_00, 10'b0000_00_00_00,
        10'b0000_01_10_00, 10'b0000_00_00_01, 10'b0011_00_00_01, 10'b0000_01_10_00,
        10'b0000_00_00_11};

    mcpu_control_fsm #(.STATE_W(6)) dut (
        .clk(clk), .reset(reset), .instruction(instruction),
        .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm(imm),
        .address(address), .state(state),
        .pc_we(pc_we), .ir_we(ir_we), .mem_we(mem_we), .reg_we(reg_we),
        .a_we(a_we), .b_we(b_we), .ben_we(ben_we), .save_pc4(save_pc4),
        .mem_in(mem_in), .dst(dst), .reg_in(reg_in), .immer(immer), .jal(jal),
        .beq_bne(beq_bne), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_src(pc_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] we_vec();
        return {pc_we, ir_we, mem_we, reg_we, a_we, b_we, ben_we, save_pc4};
    endfunction

    function automatic void build_path(input logic [31:0] ins);
        int op = int'(ins >> 26);
        int fn = int'(ins % 64);
        path.delete();
        path.push_back(1);
        if (op == 35)                                    begin path.push_back(2); path.push_back(3); path.push_back(4); end
        else if (op == 43)                               begin path.push_back(2); path.push_back(5); end
        else if (op == 0 && (fn == 32 || fn == 34 || fn == 42)) begin path.push_back(6); path.push_back(7); end
        else if (op == 0 && fn == 8)                     begin path.push_back(15); path.push_back(16); end
        else if (op == 8 || op == 14)                    begin path.push_back(8); path.push_back(9); end
        else if (op == 4 || op == 5)                     begin path.push_back(10); path.push_back(11); path.push_back(12); end
        else if (op == 2)                                path.push_back(13);
        else if (op == 3)                                path.push_back(14);
        path.push_back(0);
    endfunction

    task automatic check_outputs(input int s, input logic [31:0] ins);
        int op = int'(ins >> 26);
        int fn = int'(ins % 64);
        int e_alu = 0;
        if (s == 6)            e_alu = (fn == 34) ? 1 : (fn == 42) ? 3 : 0;
        if (s == 8 && op == 14) e_alu = 2;
        if (s == 12)           e_alu = 1;
        chk($sformatf("s%0d_state", s), 32'(state), 32'(s));
        chk($sformatf("s%0d_we", s), 32'(we_vec()), 32'(WE_T[s]));
        chk($sformatf("s%0d_mux", s),
            32'({mem_in, dst, reg_in, jal, alu_src_a, alu_src_b, pc_src}), 32'(MUX_T[s]));
        chk($sformatf("s%0d_alu_op", s), 32'(alu_op), 32'(e_alu));
        chk($sformatf("s%0d_immer_bb", s), 32'({immer, beq_bne}),
            32'({s == 8 && op == 14, s == 12 && op == 5}));
    endtask

    // Entered just after a negedge with the DUT in FETCH; leaves at the next FETCH.
    task automatic run_instr(input logic [31:0] ins);
        instruction = ins;
        #1;
        check_outputs(0, ins);
        chk("fields_lo", 32'({rs, rt, rd, shamt, funct}),
            32'({5'(ins >> 21), 5'(ins >> 16), 5'(ins >> 11), 5'(ins >> 6), 6'(ins)}));
        chk("fields_imm_addr", 32'({imm[5:0], address}), 32'({6'(ins), 26'(ins)}));
        build_path(ins);
        foreach (path[i]) begin
            @(negedge clk);
            #1;
            check_outputs(path[i], ins);
        end
    endtask

    initial begin
        logic [31:0] r;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [5:0]  fns [4];
        fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h2A; fns[3] = 6'h08;

        reset = 1'b1;
        instruction = 32'h0;
        #1;
        chk("reset_we_pre", 32'(we_vec()), 32'h0);
        @(negedge clk); #1;
        chk("reset_we_c1", 32'(we_vec()), 32'h0);
        @(negedge clk); #1;
        chk("reset_we_c2", 32'(we_vec()), 32'h0);
        chk("reset_state", 32'(state), 32'h0);
        reset = 1'b0;

        run_instr(32'h8C220004);
        run_instr(32'h00221820);
        run_instr(32'h00221822);
        run_instr(32'h0022182A);
        run_instr(32'h14220003);
        run_instr(32'h10220003);
        run_instr(32'h0C000010);
        run_instr(32'h03E00008);
        run_instr(32'hFC000000);
        run_instr(32'h3822FFFF);
        run_instr(32'h2022FFF0);
        run_instr(32'hAC220008);
        run_instr(32'h08000040);
        run_instr(32'h00221821);

        // reset asserted mid-instruction must silence enables and return to FETCH
        instruction = 32'h8C220004;
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midreset_we", 32'(we_vec()), 32'h0);
        @(negedge clk); #1;
        chk("midreset_state", 32'(state), 32'h0);
        chk("midreset_we2", 32'(we_vec()), 32'h0);
        reset = 1'b0;
        run_instr(32'h00221822);

        for (int n = 0; n < 80; n++) begin
            r = $urandom;
            case ($urandom_range(0, 11))
                0:  op = 6'h23;
                1:  op = 6'h2B;
                2:  op = 6'h00;
                3:  op = 6'h08;
                4:  op = 6'h0E;
                5:  op = 6'h04;
                6:  op = 6'h05;
                7:  op = 6'h02;
                8:  op = 6'h03;
                9:  op = 6'h00;
                default: op = r[31:26];
            endcase
            fn = r[5:0];
            if (op == 6'h00 && r[31]) fn = fns[$urandom_range(0, 3)];
            run_instr({op, r[25:6], fn});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
